// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: FSM state encoding and the
// EX/MEM payload layout that fixes the default stage width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        rd_wen;
        logic        mem_re;
        logic [31:0] csr_wdata;
        logic [31:0] csr_waddr;
        logic        csr_wen;
    } ex_mem_pkt_t;

    localparam int EX_MEM_W = $bits(ex_mem_pkt_t);

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One payload storage slot: a DATA_W register cleared by reset and written
// only when its load enable is high.
module pipe_slot #(
    parameter int DATA_W = 104
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, flush, bubble zeroing and a saturating stall counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W       = EX_MEM_W,
    parameter int SKID         = 1,
    parameter int ZERO_INVALID = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state, state_nxt;
    logic              acc, pop;
    logic              load_main, load_skid, main_from_skid;
    logic [DATA_W-1:0] main_d, main_q, skid_q;

    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_in_ready_reg
            assign in_ready = (state != FULL);
        end else begin : g_in_ready_comb
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = BUSY;
                    load_main = 1'b1;
                end
            end
            BUSY: begin
                if (acc && pop) begin
                    load_main = 1'b1;
                end else if (acc && (SKID != 0)) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides everything, including a beat accepted this cycle.
        if (flush) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (load_skid),
                .d    (in_data),
                .q    (skid_q)
            );
        end else begin : g_no_skid
            logic unused_load_skid;
            assign unused_load_skid = load_skid;
            assign skid_q           = '0;
        end
    endgenerate

    generate
        if (ZERO_INVALID != 0) begin : g_zero_bubble
            assign out_data = main_q & {DATA_W{out_valid}};
        end else begin : g_hold_bubble
            assign out_data = main_q;
        end
    endgenerate

    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: four instances (SKID x ZERO_INVALID) share one
// stimulus stream and are compared every cycle against a queue-level model.
module tb_pipe_stage_hs;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_w  [4];
    logic          out_valid_w [4];
    logic [DW-1:0] out_data_w  [4];
    logic [1:0]    occ_w       [4];
    logic [CW-1:0] stall_w     [4];

    int errors = 0;
    int checks = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pipe_stage_hs #(
            .DATA_W       (DW),
            .SKID         (g / 2),
            .ZERO_INVALID (g % 2),
            .CNT_W        (CW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_data   (in_data),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g]),
            .occupancy (occ_w[g]),
            .stall_cnt (stall_w[g])
        );
    end

    // Model: each instance is a FIFO of capacity 2 (skid) or 1, holding entries e0 (head), e1.
    int            mcnt   [4] = '{default: 0};
    int            mstall [4] = '{default: 0};
    logic [DW-1:0] me0    [4] = '{default: '0};
    logic [DW-1:0] me1    [4] = '{default: '0};
    logic [DW-1:0] mlast  [4] = '{default: '0};

    function automatic bit has_skid(int k);
        return k >= 2;
    endfunction

    function automatic bit zero_inv(int k);
        return (k % 2) == 1;
    endfunction

    function automatic bit exp_ready(int k);
        if (has_skid(k)) return mcnt[k] < 2;
        return out_ready || (mcnt[k] == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data(int k);
        if (mcnt[k] > 0) return me0[k];
        return zero_inv(k) ? '0 : mlast[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mcnt[k] = 0; mstall[k] = 0; mlast[k] = '0; me0[k] = '0; me1[k] = '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                bit a, p;
                a = in_valid && exp_ready(k);
                p = (mcnt[k] > 0) && out_ready;
                if ((mcnt[k] > 0) && !out_ready && (mstall[k] < (1 << CW) - 1)) mstall[k]++;
                if (flush) begin
                    mcnt[k] = 0;
                end else begin
                    if (p) begin
                        me0[k] = me1[k];
                        mcnt[k]--;
                    end
                    if (a) begin
                        if (mcnt[k] == 0) me0[k] = in_data;
                        else me1[k] = in_data;
                        mcnt[k]++;
                    end
                end
                if (mcnt[k] > 0) mlast[k] = me0[k];
            end
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            for (int k = 0; k < 4; k++) begin
                check("in_ready",  k, 32'(in_ready_w[k]),  32'(exp_ready(k)));
                check("out_valid", k, 32'(out_valid_w[k]), 32'(mcnt[k] > 0));
                check("out_data",  k, 32'(out_data_w[k]),  32'(exp_data(k)));
                check("occupancy", k, 32'(occ_w[k]),       32'(mcnt[k]));
                check("stall_cnt", k, 32'(stall_w[k]),     32'(mstall[k]));
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_ready", k, 32'(in_ready_w[k]), 32'd1);
            check("rst_valid", k, 32'(out_valid_w[k]), 32'd0);
            check("rst_data",  k, 32'(out_data_w[k]), 32'd0);
        end
        rst = 1'b0;
        run_cmp = 1'b1;

        // Streaming at full rate, one cycle of latency.
        step(1'b1, 16'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t2_d1", k, 32'(out_data_w[k]), 32'd1);
        step(1'b1, 16'd2, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t2_d2", k, 32'(out_data_w[k]), 32'd2);
        step(1'b1, 16'd3, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t2_d3", k, 32'(out_data_w[k]), 32'd3);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t2_empty", k, 32'(out_valid_w[k]), 32'd0);
            check("t2_bubble", k, 32'(out_data_w[k]), zero_inv(k) ? 32'd0 : 32'd3);
        end

        // Back-pressure: A, B, C offered while downstream stalls.
        pulse_reset();
        step(1'b1, 16'h00A0, 1'b0, 1'b0);
        step(1'b1, 16'h00B0, 1'b0, 1'b0);
        step(1'b1, 16'h00C0, 1'b0, 1'b0);
        check("t3_occ_skid", 2, 32'(occ_w[2]), 32'd2);
        check("t3_ready_skid", 3, 32'(in_ready_w[3]), 32'd0);
        check("t3_occ_noskid", 0, 32'(occ_w[0]), 32'd1);
        check("t3_head", 2, 32'(out_data_w[2]), 32'h00A0);
        check("t3_stalls", 2, 32'(stall_w[2]), 32'd2);
        step(1'b1, 16'h00C0, 1'b1, 1'b0);
        check("t3_out_b", 3, 32'(out_data_w[3]), 32'h00B0);
        step(1'b1, 16'h00C0, 1'b1, 1'b0);
        check("t3_out_c", 3, 32'(out_data_w[3]), 32'h00C0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("t3_drained", 2, 32'(out_valid_w[2]), 32'd0);

        // Asynchronous reset while the skid instances are full.
        pulse_reset();
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t1_valid", k, 32'(out_valid_w[k]), 32'd0);
            check("t1_occ",   k, 32'(occ_w[k]),       32'd0);
            check("t1_ready", k, 32'(in_ready_w[k]),  32'd1);
            check("t1_stall", k, 32'(stall_w[k]),     32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t1_no_ghost", k, 32'(out_valid_w[k]), 32'd0);

        // Flush wins over a same-cycle accept.
        step(1'b1, 16'h0101, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 1'b0, 1'b0);
        step(1'b1, 16'h0D0D, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check("t4_valid", k, 32'(out_valid_w[k]), 32'd0);
            check("t4_occ",   k, 32'(occ_w[k]),       32'd0);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t4_no_d", k, 32'(out_valid_w[k]), 32'd0);

        // Bubble zeroing.
        check("t5_empty", 1, 32'(out_data_w[1]), 32'd0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) check("t5_dead", k, 32'(out_data_w[k]), 32'hDEAD);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            check("t5_after", k, 32'(out_data_w[k]), zero_inv(k) ? 32'd0 : 32'hDEAD);

        // Combinational ready without skid, then counter saturation.
        pulse_reset();
        step(1'b1, 16'h0007, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1 check("t6_ready_hi", 0, 32'(in_ready_w[0]), 32'd1);
        out_ready = 1'b0;
        #1 check("t6_ready_lo", 1, 32'(in_ready_w[1]), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) check("t6_sat", k, 32'(stall_w[k]), 32'd15);

        // Mixed traffic pattern, checked by the per-cycle model only.
        pulse_reset();
        for (int i = 0; i < 48; i++)
            step((i % 3) != 0, 16'(16'h0100 + i), (i % 4) != 1, i == 25);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
